ex_sched: RTL and testbench
===========================

# ex_sched

Issue/retire sequencer for the execute stage. Accepts one decoded instruction at a time from ID over a valid/ready handshake and drives the single-cycle ALU datapath, or the shared iterative mul/div unit for multi-cycle ops. Holds the result until WB accepts it, then releases any branch/jump redirect to the PC logic in program order. Sits between ID and WB; ALU, operand muxes and next-PC logic stay combinational around it.

## Interface
Parameters:
- XLEN, 64, datapath width
- OPW, 5, ALU opcode width (matches `ALU_OP_WIDTH`)
- MD_TIMEOUT, 64, max cycles to wait for md_done (>=2)

Ports:
- clk  in  1  clock; single clock domain, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID offers an instruction
- id_ready  out  1  sequencer accepts this cycle
- id_pc  in  XLEN  instruction PC
- id_alu_op  in  OPW  ALU opcode
- id_is_md  in  1  op executes on mul/div unit
- id_rd  in  5  destination register
- id_rd_wen  in  1  writes rd
- id_redirect  in  1  instruction redirects PC (taken branch/jump)
- id_target  in  XLEN  redirect target
- alu_op  out  OPW  registered opcode to ALU
- alu_res  in  XLEN  combinational ALU result
- md_start  out  1  one-cycle start pulse to mul/div
- md_kill  out  1  one-cycle abort pulse to mul/div
- md_done  in  1  mul/div result valid (one cycle)
- md_res  in  XLEN  mul/div result
- wb_valid  out  1  result available
- wb_ready  in  1  WB takes result
- wb_pc, wb_rd, wb_wen, wb_data  out  XLEN/5/1/XLEN  retired instruction fields
- pc_redirect  out  1  redirect pulse, coincident with retirement
- pc_target  out  XLEN  redirect target
- flush  in  1  synchronous kill of in-flight instruction
- md_err  out  1  sticky: mul/div timeout occurred
- instret  out  64  retired-instruction counter

## Operation
- States: IDLE, EXEC, MD_WAIT, WB_HOLD.
- id_ready = !flush && (IDLE || (WB_HOLD && wb_ready && !redirect_q)).
- Accept (id_valid && id_ready): latch pc, op, rd, wen, redirect, target; go EXEC if !id_is_md, else MD_WAIT.
- EXEC: alu_op = latched op; at cycle end capture alu_res into wb_data; go WB_HOLD.
- MD_WAIT: md_start=1 on first cycle only; timeout counter cleared on entry, incremented each cycle. On md_done: capture md_res, go WB_HOLD. If counter reaches MD_TIMEOUT-1 without md_done: wb_data=0, set md_err, md_kill=1 for one cycle, go WB_HOLD (instruction still retires).
- md_done outside MD_WAIT ignored.
- WB_HOLD: wb_valid=1, fields stable. On wb_ready: retire, instret+1 (wraps at 2^64), pc_redirect=redirect_q with pc_target=target_q in the same cycle; next state EXEC/MD_WAIT if a new instruction is accepted that cycle, else IDLE.
- Retirement of a redirecting instruction never accepts back-to-back; ID sees id_ready=0 that cycle.
- flush (highest priority): next state IDLE, no retirement, no instret increment, no pc_redirect; md_kill=1 if current state is MD_WAIT. flush and wb_ready in the same cycle: flush wins.
- md_err cleared only by rst.

## Timing
- Reset: state IDLE; alu_op, wb_* , pc_target, instret, md_err, counter = 0; md_start, md_kill, wb_valid, pc_redirect = 0; id_ready=1 (flush low).
- ALU path: accept at edge E0, EXEC during E0-E1, wb_valid high from E1; retire at E2 earliest; 1 instruction per 2 cycles sustained.
- MD path: md_start during cycle after E0; wb_valid high the cycle after md_done is sampled.
- Timeout: wb_valid rises exactly MD_TIMEOUT cycles after MD_WAIT entry.
- wb_* outputs registered; pc_redirect, id_ready, md_start, md_kill combinational from state and inputs.
- rst mid-operation: immediate return to reset values; no md_kill issued.

## Test plan
- Reset, then id_valid with op ADD, pc=0x80000000, rd=5, wb_ready=1 -> alu_op=ADD for one cycle, wb_valid 2 edges after accept, wb_data=alu_res, instret=1.
- MD op with md_done 7 cycles after md_start, md_res=0x1234 -> single md_start pulse, wb_data=0x1234, wb_valid cycle after md_done, md_err=0.
- MD op with md_done never asserted, MD_TIMEOUT=64 -> md_kill pulse, wb_data=0, md_err=1 sticky, instruction retires.
- Redirect instruction, target=0x80000100, wb_ready held 0 for 3 cycles then 1 -> wb fields stable, pc_redirect one cycle at retirement with pc_target=0x80000100, id_ready=0 that cycle.
- flush during MD_WAIT while id_valid=1 -> md_kill=1, state IDLE, no wb_valid, instret unchanged, new instruction not accepted that cycle.
- Back-to-back ALU ops with wb_ready=1 -> accept and retire in the same cycle, instret increments every 2 cycles.

Source files
------------

// File: rtl/ex_sched_if.sv
// rtl/ex_sched_if.sv - ID/ALU/mul-div/WB signal bundle for the execute-stage sequencer
interface ex_sched_if #(
  parameter int XLEN = 64,
  parameter int OPW  = 5
);
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [OPW-1:0]  id_alu_op;
  logic            id_is_md;
  logic [4:0]      id_rd;
  logic            id_rd_wen;
  logic            id_redirect;
  logic [XLEN-1:0] id_target;
  logic [OPW-1:0]  alu_op;
  logic [XLEN-1:0] alu_res;
  logic            md_start;
  logic            md_kill;
  logic            md_done;
  logic [XLEN-1:0] md_res;
  logic            wb_valid;
  logic            wb_ready;
  logic [XLEN-1:0] wb_pc;
  logic [4:0]      wb_rd;
  logic            wb_wen;
  logic [XLEN-1:0] wb_data;
  logic            pc_redirect;
  logic [XLEN-1:0] pc_target;
  logic            flush;
  logic            md_err;
  logic [63:0]     instret;

  // master = surrounding pipeline (ID, ALU, mul/div, WB); slave = the sequencer
  modport master (
    output id_valid, id_pc, id_alu_op, id_is_md, id_rd, id_rd_wen, id_redirect, id_target,
    output alu_res, md_done, md_res, wb_ready, flush,
    input  id_ready, alu_op, md_start, md_kill, wb_valid, wb_pc, wb_rd, wb_wen, wb_data,
    input  pc_redirect, pc_target, md_err, instret
  );

  modport slave (
    input  id_valid, id_pc, id_alu_op, id_is_md, id_rd, id_rd_wen, id_redirect, id_target,
    input  alu_res, md_done, md_res, wb_ready, flush,
    output id_ready, alu_op, md_start, md_kill, wb_valid, wb_pc, wb_rd, wb_wen, wb_data,
    output pc_redirect, pc_target, md_err, instret
  );
endinterface

// File: rtl/ex_sched.sv
// rtl/ex_sched.sv - execute-stage issue/retire sequencer (ALU single-cycle, iterative mul/div, in-order redirect)
module ex_sched #(
  parameter int XLEN       = 64,
  parameter int OPW        = 5,
  parameter int MD_TIMEOUT = 64
) (
  input logic     clk,
  input logic     rst,
  ex_sched_if.slave bus
);
  localparam int CW = $clog2(MD_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MD_WAIT, WB_HOLD} state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] wb_data_q;
  logic [OPW-1:0]  alu_op_q;
  logic [4:0]      rd_q;
  logic            wen_q;
  logic            redirect_q;
  logic            wb_valid_q;
  logic            md_err_q;
  logic [63:0]     instret_q;
  logic [CW-1:0]   cnt_q;

  logic accept;
  logic retire;
  logic md_timeout;

  // A redirecting retirement must not overlap a fetch from the stale path.
  assign bus.id_ready = !bus.flush &&
                        ((state_q == IDLE) ||
                         ((state_q == WB_HOLD) && bus.wb_ready && !redirect_q));
  assign accept     = bus.id_valid && bus.id_ready;
  assign retire     = (state_q == WB_HOLD) && bus.wb_ready && !bus.flush;
  assign md_timeout = (state_q == MD_WAIT) && !bus.md_done && (cnt_q == CNT_LAST);

  assign bus.md_start    = (state_q == MD_WAIT) && (cnt_q == '0);
  assign bus.md_kill     = (state_q == MD_WAIT) && (bus.flush || md_timeout);
  assign bus.pc_redirect = retire && redirect_q;

  assign bus.alu_op    = alu_op_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_pc     = pc_q;
  assign bus.wb_rd     = rd_q;
  assign bus.wb_wen    = wen_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.pc_target = target_q;
  assign bus.md_err    = md_err_q;
  assign bus.instret   = instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      target_q   <= '0;
      wb_data_q  <= '0;
      alu_op_q   <= '0;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      redirect_q <= 1'b0;
      wb_valid_q <= 1'b0;
      md_err_q   <= 1'b0;
      instret_q  <= '0;
      cnt_q      <= '0;
    end else begin
      alu_op_q <= '0;
      if (bus.flush) begin
        state_q    <= IDLE;
        wb_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          EXEC: begin
            wb_data_q  <= bus.alu_res;
            wb_valid_q <= 1'b1;
            state_q    <= WB_HOLD;
          end
          MD_WAIT: begin
            cnt_q <= cnt_q + 1'b1;
            if (bus.md_done) begin
              wb_data_q  <= bus.md_res;
              wb_valid_q <= 1'b1;
              state_q    <= WB_HOLD;
            end else if (cnt_q == CNT_LAST) begin
              // Timed-out op still retires, with a zero result.
              wb_data_q  <= '0;
              md_err_q   <= 1'b1;
              wb_valid_q <= 1'b1;
              state_q    <= WB_HOLD;
            end
          end
          WB_HOLD: begin
            if (bus.wb_ready) begin
              instret_q  <= instret_q + 64'd1;
              wb_valid_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        endcase

        if (accept) begin
          pc_q       <= bus.id_pc;
          rd_q       <= bus.id_rd;
          wen_q      <= bus.id_rd_wen;
          redirect_q <= bus.id_redirect;
          target_q   <= bus.id_target;
          cnt_q      <= '0;
          if (bus.id_is_md) begin
            state_q <= MD_WAIT;
          end else begin
            state_q  <= EXEC;
            alu_op_q <= bus.id_alu_op;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ex_sched.sv
// tb/tb_ex_sched.sv - vector table plus scoreboard bench for ex_sched
module tb_ex_sched;
  localparam int XLEN = 64;
  localparam int OPW  = 5;
  localparam int MDT  = 64;
  localparam int NV   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_sched_if #(.XLEN(XLEN), .OPW(OPW)) bus();
  ex_sched #(.XLEN(XLEN), .OPW(OPW), .MD_TIMEOUT(MDT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  op;
    logic        is_md;
    logic [4:0]  rd;
    logic        wen;
    logic        redir;
    logic [63:0] tgt;
    int          md_delay;
    logic [63:0] md_res;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] data;
    logic        redir;
    logic [63:0] tgt;
  } sb_t;

  sb_t         sb[$];
  sb_t         mon_e;
  vec_t        vecs[NV];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          md_starts = 0;
  int          md_kills = 0;
  logic [63:0] exp_instret = 0;
  int          md_delay_cfg = 0;
  logic [63:0] md_res_cfg = 0;

  function automatic logic [63:0] alu_fn(input logic [4:0] op);
    return {8'hA5, 19'h0, op, 27'h0, op};
  endfunction

  function automatic vec_t mk(input logic [63:0] pc, input logic [4:0] op, input logic is_md,
                              input logic [4:0] rd, input logic wen, input logic redir,
                              input logic [63:0] tgt, input int dly, input logic [63:0] res,
                              input logic err);
    vec_t v;
    v.pc = pc; v.op = op; v.is_md = is_md; v.rd = rd; v.wen = wen; v.redir = redir;
    v.tgt = tgt; v.md_delay = dly; v.md_res = res; v.exp_err = err;
    v.exp_data = is_md ? ((dly == 0) ? 64'h0 : res) : alu_fn(op);
    return v;
  endfunction

  assign bus.alu_res = alu_fn(bus.alu_op);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Mul/div stand-in: md_done pulses md_delay_cfg cycles after the md_start cycle; 0 = never.
  logic s_start, s_kill;
  int   md_left = 0;
  bit   md_pend = 0;
  initial begin
    bus.md_done = 1'b0;
    bus.md_res  = '0;
    forever begin
      @(negedge clk);
      s_start = bus.md_start;
      s_kill  = bus.md_kill;
      @(posedge clk);
      #1;
      bus.md_done = 1'b0;
      if (rst || s_kill) md_pend = 0;
      if (s_start && !rst && md_delay_cfg > 0) begin
        md_pend = 1;
        md_left = md_delay_cfg;
      end
      if (md_pend) begin
        md_left--;
        if (md_left == 0) begin
          bus.md_done = 1'b1;
          bus.md_res  = md_res_cfg;
          md_pend     = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.md_kill) md_kills++;
      if (bus.md_start) md_starts++;
      if (bus.wb_valid && bus.wb_ready && !bus.flush) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_retire: wb_pc 0x%0h retired with empty scoreboard", bus.wb_pc);
        end else begin
          mon_e = sb.pop_front();
          chk("wb_pc", bus.wb_pc, mon_e.pc);
          chk("wb_rd", 64'(bus.wb_rd), 64'(mon_e.rd));
          chk("wb_wen", 64'(bus.wb_wen), 64'(mon_e.wen));
          chk("wb_data", bus.wb_data, mon_e.data);
          chk("pc_redirect", 64'(bus.pc_redirect), 64'(mon_e.redir));
          if (mon_e.redir) chk("pc_target", bus.pc_target, mon_e.tgt);
          exp_instret++;
        end
      end else begin
        chk("pc_redirect_quiet", 64'(bus.pc_redirect), 64'd0);
      end
    end
  end

  task automatic drive(input vec_t v);
    bus.id_pc       = v.pc;
    bus.id_alu_op   = v.op;
    bus.id_is_md    = v.is_md;
    bus.id_rd       = v.rd;
    bus.id_rd_wen   = v.wen;
    bus.id_redirect = v.redir;
    bus.id_target   = v.tgt;
    md_delay_cfg    = v.md_delay;
    md_res_cfg      = v.md_res;
    bus.id_valid    = 1'b1;
  endtask

  task automatic push(input vec_t v);
    sb.push_back('{pc: v.pc, rd: v.rd, wen: v.wen, data: v.exp_data, redir: v.redir, tgt: v.tgt});
  endtask

  task automatic issue(input vec_t v);
    bit ok;
    ok = 0;
    drive(v);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.id_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.id_valid = 1'b0;
    if (ok) push(v);
    else chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_wb_valid(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.wb_valid) begin
        seen = 1;
        break;
      end
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  int   s0, k0, lat, exp_lat, prev_acc, acc_cyc;
  vec_t v, n;

  initial begin
    bus.id_valid = 1'b0; bus.id_pc = '0; bus.id_alu_op = '0; bus.id_is_md = 1'b0;
    bus.id_rd = '0; bus.id_rd_wen = 1'b0; bus.id_redirect = 1'b0; bus.id_target = '0;
    bus.wb_ready = 1'b1; bus.flush = 1'b0;

    vecs[0] = mk(64'h8000_0000, 5'd1,  1'b0, 5'd5,  1'b1, 1'b0, 64'h0, 0, 64'h0, 1'b0);
    vecs[1] = mk(64'h8000_0004, 5'd7,  1'b0, 5'd31, 1'b0, 1'b0, 64'h0, 0, 64'h0, 1'b0);
    vecs[2] = mk(64'h8000_0008, 5'd0,  1'b1, 5'd10, 1'b1, 1'b0, 64'h0, 7, 64'h1234, 1'b0);
    vecs[3] = mk(64'h8000_000C, 5'd0,  1'b1, 5'd0,  1'b1, 1'b0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    vecs[4] = mk(64'hFFFF_FFFF_FFFF_FFFC, 5'd31, 1'b0, 5'd17, 1'b1, 1'b1, 64'h8000_0200, 0, 64'h0, 1'b0);
    vecs[5] = mk(64'h8000_0010, 5'd0,  1'b1, 5'd12, 1'b1, 1'b0, 64'h0, MDT - 1, 64'hCAFE_F00D_0000_0001, 1'b0);
    vecs[6] = mk(64'h8000_0014, 5'd0,  1'b1, 5'd13, 1'b1, 1'b0, 64'h0, 0, 64'h5555, 1'b1);
    vecs[7] = mk(64'h8000_0020, 5'd0,  1'b0, 5'd3,  1'b1, 1'b0, 64'h0, 0, 64'h0, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_instret", bus.instret, 64'd0);
    chk("rst_md_err", 64'(bus.md_err), 64'd0);
    chk("rst_id_ready", 64'(bus.id_ready), 64'd1);
    chk("rst_alu_op", 64'(bus.alu_op), 64'd0);
    chk("rst_wb_data", bus.wb_data, 64'd0);
    chk("rst_pc_target", bus.pc_target, 64'd0);
    chk("rst_md_start", 64'(bus.md_start), 64'd0);
    chk("rst_md_kill", 64'(bus.md_kill), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      s0 = md_starts;
      k0 = md_kills;
      exp_lat = !vecs[i].is_md ? 1 : ((vecs[i].md_delay == 0) ? MDT : vecs[i].md_delay + 1);
      issue(vecs[i]);
      lat = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (c == 0) chk("alu_op_exec", 64'(bus.alu_op), vecs[i].is_md ? 64'd0 : 64'(vecs[i].op));
        if (bus.wb_valid) break;
        lat++;
      end
      chk("wb_latency", 64'(lat), 64'(exp_lat));
      chk("alu_op_after", 64'(bus.alu_op), 64'd0);
      drain();
      chk("md_err", 64'(bus.md_err), 64'(vecs[i].exp_err));
      chk("instret", bus.instret, exp_instret);
      chk("md_start_count", 64'(md_starts - s0), 64'(vecs[i].is_md));
      chk("md_kill_count", 64'(md_kills - k0),
          64'(vecs[i].is_md && vecs[i].md_delay == 0));
    end

    // Redirect held at WB for 3 cycles, then released; ID must wait one extra cycle.
    v = mk(64'h8000_0040, 5'd3, 1'b0, 5'd1, 1'b1, 1'b1, 64'h8000_0100, 0, 64'h0, 1'b1);
    n = mk(64'h8000_0100, 5'd9, 1'b0, 5'd2, 1'b1, 1'b0, 64'h0, 0, 64'h0, 1'b1);
    bus.wb_ready = 1'b0;
    issue(v);
    wait_wb_valid("redir_wb_valid");
    for (int h = 0; h < 3; h++) begin
      chk("hold_wb_valid", 64'(bus.wb_valid), 64'd1);
      chk("hold_wb_pc", bus.wb_pc, v.pc);
      chk("hold_wb_data", bus.wb_data, v.exp_data);
      chk("hold_id_ready", 64'(bus.id_ready), 64'd0);
      @(posedge clk);
      #1;
      if (h < 2) @(negedge clk);
    end
    bus.wb_ready = 1'b1;
    drive(n);
    @(negedge clk);
    chk("redir_pulse", 64'(bus.pc_redirect), 64'd1);
    chk("redir_target", bus.pc_target, 64'h8000_0100);
    chk("redir_id_ready", 64'(bus.id_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("after_redir_id_ready", 64'(bus.id_ready), 64'd1);
    chk("after_redir_wb_valid", 64'(bus.wb_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.id_valid = 1'b0;
    push(n);
    drain();

    // Flush during MD_WAIT with a new instruction offered.
    v = mk(64'h8000_0300, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 64'h0, 0, 64'h0, 1'b1);
    issue(v);
    void'(sb.pop_back());
    k0 = md_kills;
    repeat (3) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    drive(n);
    @(negedge clk);
    chk("flush_md_kill", 64'(bus.md_kill), 64'd1);
    chk("flush_id_ready", 64'(bus.id_ready), 64'd0);
    chk("flush_wb_valid", 64'(bus.wb_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.id_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_id_ready", 64'(bus.id_ready), 64'd1);
    chk("flush_idle_md_start", 64'(bus.md_start), 64'd0);
    repeat (4) @(negedge clk);
    chk("flush_no_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("flush_instret", bus.instret, exp_instret);
    chk("flush_kill_count", 64'(md_kills - k0), 64'd1);

    // flush beats wb_ready on a redirecting instruction.
    v = mk(64'h8000_0400, 5'd6, 1'b0, 5'd8, 1'b1, 1'b1, 64'h8000_0500, 0, 64'h0, 1'b1);
    @(posedge clk);
    #1;
    bus.wb_ready = 1'b0;
    issue(v);
    void'(sb.pop_back());
    wait_wb_valid("fw_wb_valid");
    @(posedge clk);
    #1;
    bus.flush = 1'b1;
    bus.wb_ready = 1'b1;
    @(negedge clk);
    chk("fw_pc_redirect", 64'(bus.pc_redirect), 64'd0);
    chk("fw_id_ready", 64'(bus.id_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("fw_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("fw_instret", bus.instret, exp_instret);
    @(posedge clk);
    #1;

    // Back-to-back ALU ops: accept and retire share a cycle, one op per 2 cycles.
    prev_acc = 0;
    for (int i = 0; i < 5; i++) begin
      bit ok;
      v = mk(64'h8000_1000 + 64'(4 * i), 5'(i + 2), 1'b0, 5'(i + 1), 1'b1, 1'b0, 64'h0, 0, 64'h0, 1'b1);
      drive(v);
      ok = 0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (bus.id_ready) begin
          ok = 1;
          break;
        end
      end
      chk("b2b_accept", 64'(ok), 64'd1);
      acc_cyc = cyc;
      if (i > 0) begin
        chk("b2b_interval", 64'(acc_cyc - prev_acc), 64'd2);
        chk("b2b_retire_same_cycle", 64'(bus.wb_valid), 64'd1);
      end
      prev_acc = acc_cyc;
      @(posedge clk);
      #1;
      if (ok) push(v);
    end
    bus.id_valid = 1'b0;
    drain();
    chk("b2b_instret", bus.instret, exp_instret);

    // Reset mid-MD_WAIT: everything returns to reset values, no kill pulse, md_err cleared.
    v = mk(64'h8000_2000, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 64'h0, 0, 64'h0, 1'b1);
    issue(v);
    void'(sb.pop_back());
    k0 = md_kills;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_md_err", 64'(bus.md_err), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_md_kill", 64'(bus.md_kill), 64'd0);
    chk("midrst_md_err", 64'(bus.md_err), 64'd0);
    chk("midrst_instret", bus.instret, 64'd0);
    chk("midrst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("midrst_md_start", 64'(bus.md_start), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_instret = 0;
    @(negedge clk);
    chk("postrst_id_ready", 64'(bus.id_ready), 64'd1);
    chk("midrst_kill_count", 64'(md_kills - k0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end
endmodule
